// File: rtl/counter_timer_high.sv
// Upper 32-bit word of a chained 64-bit counter/timer; also works standalone.
// CONFIG/VALUE/DATA register ports match the low-word counter's wishbone wrapper.
module counter_timer_high (
   input  logic        clkin,
   input  logic        resetn,
   input  logic        reg_cfg_we,
   input  logic [31:0] reg_cfg_di,
   output logic [31:0] reg_cfg_do,
   input  logic [3:0]  reg_val_we,
   input  logic [31:0] reg_val_di,
   output logic [31:0] reg_val_do,
   input  logic [3:0]  reg_dat_we,
   input  logic [31:0] reg_dat_di,
   output logic [31:0] reg_dat_do,
   input  logic        enable_in,
   input  logic        strobe,
   input  logic        is_offset,
   input  logic        stop_in,
   output logic        enable_out,
   output logic        stop_out,
   output logic        irq_out
);

   logic [4:0]  r_cfg;
   logic [31:0] r_val;
   logic [31:0] r_cnt;
   logic        r_stop;
   logic        r_irq;
   logic        r_lastenable;

   logic        w_enable;
   logic        w_oneshot;
   logic        w_updown;
   logic        w_chain;
   logic        w_irq_ena;
   logic        w_run_en;
   logic [31:0] w_term;
   logic [31:0] w_load;
   logic [31:0] w_step;
   logic        w_at_term;
   logic        w_step_term;
   logic [31:0] w_cnt_nxt;
   logic        w_stop_nxt;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  we);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (we[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
      end
      return res;
   endfunction

   assign w_enable  = r_cfg[0];
   assign w_oneshot = r_cfg[1];
   assign w_updown  = r_cfg[2];
   assign w_chain   = r_cfg[3];
   assign w_irq_ena = r_cfg[4];

   assign w_run_en = w_chain ? (w_enable & enable_in) : w_enable;

   // With the low word counting up from 0 (is_offset), the high word's
   // terminal value is one less so the 64-bit period still equals R.
   assign w_term      = w_updown ? (r_val - {31'b0, is_offset}) : 32'h0;
   assign w_load      = w_updown ? 32'h0 : r_val;
   assign w_step      = w_updown ? (r_cnt + 32'h1) : (r_cnt - 32'h1);
   assign w_at_term   = (r_cnt == w_term);
   assign w_step_term = (w_step == w_term);

   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_stop_nxt = r_stop;
      if (!w_run_en) begin
         w_cnt_nxt  = r_cnt;
         w_stop_nxt = r_stop;
      end else if (!r_lastenable) begin
         w_cnt_nxt  = w_load;
         w_stop_nxt = 1'b0;
      end else if (!w_chain) begin
         if (w_at_term) begin
            if (w_oneshot) begin
               w_stop_nxt = 1'b1;
            end else begin
               w_cnt_nxt  = w_load;
               w_stop_nxt = 1'b0;
            end
         end else begin
            w_cnt_nxt  = w_step;
            w_stop_nxt = w_step_term;
         end
      end else if (stop_in && !w_oneshot) begin
         // Low word hit its terminal with us: reload the whole 64-bit count.
         w_cnt_nxt  = w_load;
         w_stop_nxt = 1'b0;
      end else if (strobe) begin
         if (!w_at_term) begin
            w_cnt_nxt  = w_step;
            w_stop_nxt = w_step_term;
         end else if (w_oneshot) begin
            w_stop_nxt = 1'b1;
         end else begin
            w_cnt_nxt  = w_load;
            w_stop_nxt = 1'b0;
         end
      end else begin
         w_stop_nxt = w_at_term;
      end
   end

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         r_cfg <= 5'h0;
         r_val <= 32'h0;
      end else begin
         if (reg_cfg_we) r_cfg <= reg_cfg_di[4:0];
         if (|reg_val_we) r_val <= byte_merge(r_val, reg_val_di, reg_val_we);
      end
   end

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         r_cnt        <= 32'h0;
         r_stop       <= 1'b0;
         r_irq        <= 1'b0;
         r_lastenable <= 1'b0;
      end else begin
         r_lastenable <= w_run_en;
         if (|reg_dat_we) begin
            r_cnt <= byte_merge(r_cnt, reg_dat_di, reg_dat_we);
         end else begin
            r_cnt  <= w_cnt_nxt;
            r_stop <= w_stop_nxt;
            // In chained mode the low-word counter owns the interrupt.
            if (w_run_en) r_irq <= w_irq_ena & r_stop & ~w_chain;
         end
      end
   end

   assign reg_cfg_do = {27'h0, r_cfg};
   assign reg_val_do = r_val;
   assign reg_dat_do = r_cnt;
   assign enable_out = w_enable;
   assign stop_out   = r_stop;
   assign irq_out    = r_irq;

endmodule

// File: tb/tb_counter_timer_high.sv
// Directed bench for counter_timer_high: unchained/chained counting, offset
// terminal, DATA write priority, async reset and enable_in gating.
module tb_counter_timer_high;

   logic        clkin = 1'b0;
   logic        resetn;
   logic        reg_cfg_we;
   logic [31:0] reg_cfg_di;
   logic [31:0] reg_cfg_do;
   logic [3:0]  reg_val_we;
   logic [31:0] reg_val_di;
   logic [31:0] reg_val_do;
   logic [3:0]  reg_dat_we;
   logic [31:0] reg_dat_di;
   logic [31:0] reg_dat_do;
   logic        enable_in;
   logic        strobe;
   logic        is_offset;
   logic        stop_in;
   logic        enable_out;
   logic        stop_out;
   logic        irq_out;

   int n_cmp = 0;
   int n_err = 0;

   counter_timer_high dut (
      .clkin      (clkin),
      .resetn     (resetn),
      .reg_cfg_we (reg_cfg_we),
      .reg_cfg_di (reg_cfg_di),
      .reg_cfg_do (reg_cfg_do),
      .reg_val_we (reg_val_we),
      .reg_val_di (reg_val_di),
      .reg_val_do (reg_val_do),
      .reg_dat_we (reg_dat_we),
      .reg_dat_di (reg_dat_di),
      .reg_dat_do (reg_dat_do),
      .enable_in  (enable_in),
      .strobe     (strobe),
      .is_offset  (is_offset),
      .stop_in    (stop_in),
      .enable_out (enable_out),
      .stop_out   (stop_out),
      .irq_out    (irq_out)
   );

   always #5 clkin = ~clkin;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic do_reset();
      resetn     = 1'b0;
      reg_cfg_we = 1'b0; reg_cfg_di = 32'h0;
      reg_val_we = 4'h0; reg_val_di = 32'h0;
      reg_dat_we = 4'h0; reg_dat_di = 32'h0;
      enable_in  = 1'b0; strobe = 1'b0; is_offset = 1'b0; stop_in = 1'b0;
      #3;
      resetn = 1'b1;
   endtask

   task automatic wr_val(input logic [31:0] v);
      reg_val_we = 4'hF; reg_val_di = v;
      tick();
      reg_val_we = 4'h0;
   endtask

   task automatic wr_cfg(input logic [31:0] v);
      reg_cfg_we = 1'b1; reg_cfg_di = v;
      tick();
      reg_cfg_we = 1'b0;
   endtask

   task automatic wr_dat(input logic [3:0] we, input logic [31:0] v);
      reg_dat_we = we; reg_dat_di = v;
      tick();
      reg_dat_we = 4'h0;
   endtask

   initial begin
      // Reset state
      do_reset();
      resetn = 1'b0;
      #1;
      chk("rst_cfg",  reg_cfg_do, 32'h0);
      chk("rst_val",  reg_val_do, 32'h0);
      chk("rst_cnt",  reg_dat_do, 32'h0);
      chk("rst_stop", {31'h0, stop_out}, 32'h0);
      chk("rst_irq",  {31'h0, irq_out}, 32'h0);
      chk("rst_en",   {31'h0, enable_out}, 32'h0);
      resetn = 1'b1;
      tick();

      // Unchained down count, R=3
      wr_val(32'd3);
      wr_cfg(32'h01);
      chk("dn_cfg_rd", reg_cfg_do, 32'h01);
      chk("dn_en_out", {31'h0, enable_out}, 32'h1);
      chk("dn_pre",  reg_dat_do, 32'd0);
      tick(); chk("dn_start", reg_dat_do, 32'd3); chk("dn_stop0", {31'h0, stop_out}, 32'h0);
      tick(); chk("dn_c2", reg_dat_do, 32'd2); chk("dn_stop2", {31'h0, stop_out}, 32'h0);
      tick(); chk("dn_c1", reg_dat_do, 32'd1); chk("dn_stop1", {31'h0, stop_out}, 32'h0);
      tick(); chk("dn_c0", reg_dat_do, 32'd0); chk("dn_stop_t", {31'h0, stop_out}, 32'h1);
      tick(); chk("dn_wrap", reg_dat_do, 32'd3); chk("dn_stop_w", {31'h0, stop_out}, 32'h0);
      chk("dn_irq", {31'h0, irq_out}, 32'h0);

      // Unchained up oneshot with IRQ, R=2
      do_reset();
      tick();
      wr_val(32'd2);
      wr_cfg(32'h17);
      tick(); chk("os_start", reg_dat_do, 32'd0);
      tick(); chk("os_c1", reg_dat_do, 32'd1); chk("os_stop1", {31'h0, stop_out}, 32'h0);
      tick(); chk("os_c2", reg_dat_do, 32'd2); chk("os_stop2", {31'h0, stop_out}, 32'h1);
      chk("os_irq_lag", {31'h0, irq_out}, 32'h0);
      tick(); chk("os_hold", reg_dat_do, 32'd2); chk("os_irq", {31'h0, irq_out}, 32'h1);
      tick(); tick();
      chk("os_hold2", reg_dat_do, 32'd2);
      chk("os_stop_h", {31'h0, stop_out}, 32'h1);
      chk("os_irq_h", {31'h0, irq_out}, 32'h1);

      // Chained up count, R=5, strobe every 4 cycles
      do_reset();
      tick();
      enable_in = 1'b1;
      wr_val(32'd5);
      wr_cfg(32'h0D);
      tick(); chk("ch_start", reg_dat_do, 32'd0);
      for (int k = 1; k <= 5; k++) begin
         tick(); tick(); tick();
         strobe = 1'b1;
         tick();
         strobe = 1'b0;
         chk($sformatf("ch_step%0d", k), reg_dat_do, k);
         chk($sformatf("ch_stop%0d", k), {31'h0, stop_out}, (k == 5) ? 32'h1 : 32'h0);
      end
      tick(); chk("ch_hold_stop", {31'h0, stop_out}, 32'h1); chk("ch_hold_c", reg_dat_do, 32'd5);
      stop_in = 1'b1;
      tick();
      stop_in = 1'b0;
      chk("ch_reload", reg_dat_do, 32'd0);
      chk("ch_reload_stop", {31'h0, stop_out}, 32'h0);
      chk("ch_irq", {31'h0, irq_out}, 32'h0);

      // is_offset: R=1 -> T=0; then R=0 -> T=0xFFFFFFFF
      do_reset();
      tick();
      enable_in = 1'b1; is_offset = 1'b1;
      wr_val(32'd1);
      wr_cfg(32'h0D);
      tick(); chk("off_start_c", reg_dat_do, 32'd0); chk("off_start_s", {31'h0, stop_out}, 32'h0);
      tick(); chk("off_t0_stop", {31'h0, stop_out}, 32'h1);
      wr_val(32'd0);
      tick(); chk("off_tmax_nostop", {31'h0, stop_out}, 32'h0);
      wr_dat(4'hF, 32'hFFFF_FFFE);
      chk("off_dat_wr", reg_dat_do, 32'hFFFF_FFFE);
      strobe = 1'b1;
      tick(); chk("off_tmax_c", reg_dat_do, 32'hFFFF_FFFF); chk("off_tmax_s", {31'h0, stop_out}, 32'h1);
      tick(); chk("off_wrap_c", reg_dat_do, 32'h0); chk("off_wrap_s", {31'h0, stop_out}, 32'h0);
      strobe = 1'b0;

      // DATA write wins over a strobe step
      wr_dat(4'hF, 32'h1234_5600);
      chk("dw_full", reg_dat_do, 32'h1234_5600);
      strobe = 1'b1;
      wr_dat(4'h1, 32'h0000_00AA);
      chk("dw_byte", reg_dat_do, 32'h1234_56AA);
      tick();
      strobe = 1'b0;
      chk("dw_next_step", reg_dat_do, 32'h1234_56AB);

      // Asynchronous reset mid-run
      is_offset = 1'b0;
      wr_dat(4'hF, 32'h0000_1234);
      chk("ar_pre", reg_dat_do, 32'h0000_1234);
      #2;
      resetn = 1'b0;
      #1;
      chk("ar_cnt",  reg_dat_do, 32'h0);
      chk("ar_cfg",  reg_cfg_do, 32'h0);
      chk("ar_val",  reg_val_do, 32'h0);
      chk("ar_stop", {31'h0, stop_out}, 32'h0);
      chk("ar_irq",  {31'h0, irq_out}, 32'h0);
      chk("ar_en",   {31'h0, enable_out}, 32'h0);
      resetn = 1'b1;
      tick();

      // enable_in low freezes a chained count; rising E restarts from L
      enable_in = 1'b1;
      wr_val(32'd5);
      wr_cfg(32'h0D);
      tick();
      strobe = 1'b1;
      tick(); tick();
      chk("fz_pre", reg_dat_do, 32'd2);
      enable_in = 1'b0;
      tick(); tick(); tick();
      chk("fz_hold", reg_dat_do, 32'd2);
      chk("fz_en_out", {31'h0, enable_out}, 32'h1);
      chk("fz_val_rd", reg_val_do, 32'd5);
      strobe = 1'b0;
      enable_in = 1'b1;
      tick();
      chk("fz_restart", reg_dat_do, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
